// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage MIPS pipeline plus the EX/MEM pipeline register.
// Forwarding from EX/MEM (this block's own registered outputs) and MEM/WB,
// ALU, branch target, destination select, and a flush that captures a bubble.
module ex_mem_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [WIDTH-1:0]   ex_pcplus4,
    input  logic [WIDTH-1:0]   ex_readdata1,
    input  logic [WIDTH-1:0]   ex_readdata2,
    input  logic [WIDTH-1:0]   ex_signext,
    input  logic [REGADDR-1:0] ex_rs,
    input  logic [REGADDR-1:0] ex_rt,
    input  logic [REGADDR-1:0] ex_rd,
    input  logic               ex_alusrc,
    input  logic               ex_regdst,
    input  logic [1:0]         ex_aluop,
    input  logic               ex_branch,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic               ex_regwrite,
    input  logic               ex_memtoreg,
    input  logic               wb_regwrite,
    input  logic [REGADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0]   wb_data,
    output logic [WIDTH-1:0]   mem_aluresult,
    output logic [WIDTH-1:0]   mem_writedata,
    output logic [WIDTH-1:0]   mem_branchtarget,
    output logic               mem_zero,
    output logic               mem_branchtaken,
    output logic [REGADDR-1:0] mem_rd,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_regwrite,
    output logic               mem_memtoreg
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ZERO = 4'b1111;  // unknown funct / aluop 11

    logic [WIDTH-1:0]   aluresult_q, aluresult_d;
    logic [WIDTH-1:0]   writedata_q, writedata_d;
    logic [WIDTH-1:0]   branchtarget_q, branchtarget_d;
    logic               zero_q, zero_d;
    logic               branchtaken_q, branchtaken_d;
    logic [REGADDR-1:0] rd_q, rd_d;
    logic               memread_q, memread_d;
    logic               memwrite_q, memwrite_d;
    logic               regwrite_q, regwrite_d;
    logic               memtoreg_q, memtoreg_d;

    logic [WIDTH-1:0]   fwd_a, fwd_b, alu_b, alu_y;
    logic [3:0]         alu_ctrl;

    // Forwarding muxes: EX/MEM has priority over MEM/WB, register 0 never forwards.
    always_comb begin
        fwd_a = ex_readdata1;
        if (regwrite_q && (rd_q != '0) && (rd_q == ex_rs))
            fwd_a = aluresult_q;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd_a = wb_data;

        fwd_b = ex_readdata2;
        if (regwrite_q && (rd_q != '0) && (rd_q == ex_rt))
            fwd_b = aluresult_q;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt))
            fwd_b = wb_data;

        alu_b = ex_alusrc ? ex_signext : fwd_b;
    end

    // ALU control decode from aluop and the funct field of the immediate.
    always_comb begin
        alu_ctrl = ALU_ZERO;
        case (ex_aluop)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            2'b10: begin
                case (ex_signext[5:0])
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ZERO;
                endcase
            end
            default: alu_ctrl = ALU_ZERO;
        endcase
    end

    // ALU datapath; add/sub wrap, slt is a signed compare.
    always_comb begin
        alu_y = '0;
        case (alu_ctrl)
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_ADD: alu_y = fwd_a + alu_b;
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
            default: alu_y = '0;
        endcase
    end

    // Next-state of the EX/MEM register; flush clears only control bits.
    always_comb begin
        aluresult_d    = alu_y;
        writedata_d    = fwd_b;
        branchtarget_d = ex_pcplus4 + {ex_signext[WIDTH-3:0], 2'b00};
        zero_d         = (alu_y == '0);
        rd_d           = ex_regdst ? ex_rd : ex_rt;
        branchtaken_d  = ex_branch && zero_d && !flush;
        memread_d      = ex_memread  && !flush;
        memwrite_d     = ex_memwrite && !flush;
        regwrite_d     = ex_regwrite && !flush;
        memtoreg_d     = ex_memtoreg && !flush;
    end

    // EX/MEM pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            aluresult_q    <= '0;
            writedata_q    <= '0;
            branchtarget_q <= '0;
            zero_q         <= 1'b0;
            branchtaken_q  <= 1'b0;
            rd_q           <= '0;
            memread_q      <= 1'b0;
            memwrite_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
        end else begin
            aluresult_q    <= aluresult_d;
            writedata_q    <= writedata_d;
            branchtarget_q <= branchtarget_d;
            zero_q         <= zero_d;
            branchtaken_q  <= branchtaken_d;
            rd_q           <= rd_d;
            memread_q      <= memread_d;
            memwrite_q     <= memwrite_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
        end
    end

    assign mem_aluresult    = aluresult_q;
    assign mem_writedata    = writedata_q;
    assign mem_branchtarget = branchtarget_q;
    assign mem_zero         = zero_q;
    assign mem_branchtaken  = branchtaken_q;
    assign mem_rd           = rd_q;
    assign mem_memread      = memread_q;
    assign mem_memwrite     = memwrite_q;
    assign mem_regwrite     = regwrite_q;
    assign mem_memtoreg     = memtoreg_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline plus the EX/MEM pipeline register.
- Consumes the ID/EX register outputs: operands, sign-extended immediate, RS/RT/RD and EX/MEM/WB control bits.
- Resolves EX-stage data forwarding from EX/MEM and MEM/WB, computes ALU result, branch target and destination register.
- Registers everything for the MEM stage, with a flush that turns the captured instruction into a bubble.

Parameters:
- WIDTH, 32, datapath width (PC, operands, ALU result).
- REGADDR, 5, register-address width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  capture a bubble instead of the current EX instruction
- ex_pcplus4  input  WIDTH  PC+4 from ID/EX
- ex_readdata1  input  WIDTH  RS operand from ID/EX
- ex_readdata2  input  WIDTH  RT operand from ID/EX
- ex_signext  input  WIDTH  sign-extended immediate; [5:0] is the funct code
- ex_rs, ex_rt, ex_rd  input  REGADDR  register addresses from ID/EX
- ex_alusrc, ex_regdst  input  1  EX control
- ex_aluop  input  2  EX control
- ex_branch, ex_memread, ex_memwrite  input  1  MEM control
- ex_regwrite, ex_memtoreg  input  1  WB control
- wb_regwrite  input  1  MEM/WB RegWrite (forwarding source)
- wb_rd  input  REGADDR  MEM/WB destination register
- wb_data  input  WIDTH  MEM/WB MemtoReg mux output
- mem_aluresult  output  WIDTH  registered ALU result
- mem_writedata  output  WIDTH  registered forwarded RT value (store data)
- mem_branchtarget  output  WIDTH  registered pcplus4 + (signext << 2)
- mem_zero  output  1  registered ALU zero flag
- mem_branchtaken  output  1  registered branch AND zero (drives PCSrc)
- mem_rd  output  REGADDR  registered destination register
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  output  1  registered control

Behaviour:
- Reset (sync, active-high): every output is 0 on the next edge. Reset has priority over flush and capture.
- Latency: EX inputs are visible at the outputs exactly one edge later. Capture happens every cycle; there is no stall/hold.
- Flush=1 (no reset):
  - mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_branchtaken are captured as 0.
  - Data fields (aluresult, writedata, branchtarget, zero, rd) are captured normally. They are don't-care downstream.
- Forwarding, operand A (RS); first match wins:
  1. mem_regwrite && mem_rd != 0 && mem_rd == ex_rs -> mem_aluresult.
  2. wb_regwrite && wb_rd != 0 && wb_rd == ex_rs -> wb_data.
  3. Otherwise ex_readdata1.
- Forwarding, operand B (RT): same rule with ex_rt and ex_readdata2.
  - The forwarded RT goes to mem_writedata.
  - Operand B is the ex_signext when ex_alusrc=1, else the forwarded RT.
- EX/MEM always wins over MEM/WB when both match. Register 0 is never forwarded.
- Load-use hazards are handled upstream by bubble insertion. This block does not check mem_memtoreg when forwarding.
- ALU control (4-bit internal code):
  - aluop 00 -> add (0010).
  - aluop 01 -> sub (0110).
  - aluop 10 -> decode funct: 100000 add, 100010 sub, 100100 and (0000), 100101 or (0001), 101010 slt (0111).
  - Unknown funct, or aluop 11 -> result 0.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH, no overflow trap.
  - slt is a signed compare; result is 1 or 0, zero-extended.
  - zero = (result == 0).
- Branch target: ex_pcplus4 + {ex_signext[WIDTH-3:0],2'b00}, wrapping modulo 2^WIDTH.
- mem_branchtaken = ex_branch && zero, gated by flush.
- Destination register: mem_rd = ex_regdst ? ex_rd : ex_rt.
- Simultaneous write-back: a MEM/WB write to the same register as EX/MEM in the same cycle uses the EX/MEM value. Forward mux selection is purely combinational on the current cycle's inputs.

Test Plan:
- Reset then release: assert reset 1 cycle with nonzero inputs -> all outputs 0 on that edge. The next edge captures the inputs.
- R-type, no hazard: aluop=10, funct=100010, rs=5 (readdata1=10), rt=6 (readdata2=3), regdst=1, rd=7, regwrite=1 -> next edge: aluresult=7, rd=7, zero=0, regwrite=1.
- Double forwarding priority:
  - Cycle N: add writes r8=100 (in EX/MEM).
  - wb_regwrite=1, wb_rd=8, wb_data=55.
  - EX instruction uses rs=8, rt=0, aluop=00, alusrc=0, readdata2=0.
  - Response: aluresult=100 (EX/MEM wins). With wb_rd=9 and readdata1=1 instead, rs=9 -> 55 is forwarded.
- Branch: branch=1, aluop=01, readdata1=readdata2=0x2A, pcplus4=0x40, signext=0xFFFFFFFE.
  - Response: zero=1, branchtaken=1, branchtarget=0x38.
  - Repeat with flush=1 -> branchtaken=0 and all controls 0; branchtarget is still 0x38.
- slt signed and sw store data: aluop=10, funct=101010, A=0xFFFFFFFF, B=1 -> aluresult=1. Then sw with alusrc=1, signext=4, A=0x100, rt forwarded from wb_data=0xDEAD -> aluresult=0x104, writedata=0xDEAD, memwrite=1.
- Register-0 guard: mem_regwrite=1 with mem_rd=0 and ex_rs=0, readdata1=0 -> operand A is 0 (no forward). aluop=11 -> aluresult=0, zero=1.
